// File: rtl/npu_cube_add_pipe_acc.sv
// Cube adder-tree final level: registered 3:2 CSA, registered CPA, beat accumulator.
// Optional saturating accumulate with overflow flag: define NPU_CUBE_ACC_SAT_EN.
module npu_cube_add_pipe_acc #(
    parameter int DW     = 19,
    parameter int DWAUX  = 15,
    parameter int CAY_SH = 1,
    parameter int AUX_SH = 5,
    parameter int DWACC  = 32,
    parameter int LENW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_sum,
    input  logic [DW-1:0]    in_cay,
    input  logic [DWAUX-1:0] in_aux,
    input  logic [LENW-1:0]  cfg_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DWACC-1:0] out_data,
    output logic             out_ovf
);

    logic             stall;

    logic             s1_v_q, s1_v_d;
    logic [DW-1:0]    s1_sum_q, s1_sum_d;
    logic [DW-1:0]    s1_cay_q, s1_cay_d;

    logic             s2_v_q, s2_v_d;
    logic [DWACC-1:0] s2_val_q, s2_val_d;

    logic [DWACC-1:0] acc_q, acc_d;
    logic [LENW-1:0]  cnt_q, cnt_d;
    logic [LENW-1:0]  len_q, len_d;

    logic             out_valid_q, out_valid_d;
    logic [DWACC-1:0] out_data_q, out_data_d;

    logic [DW-1:0]    op_a, op_b, op_c, aux_ext;
    logic [DW-1:0]    cpa;
    logic [LENW-1:0]  len_eff;
    logic [LENW:0]    cnt_inc;
    logic [DWACC-1:0] acc_nxt;

`ifdef NPU_CUBE_ACC_SAT_EN
    logic             ovf_q, ovf_d;
    logic             out_ovf_q, out_ovf_d;
    logic             ovf_nxt;
    logic [DWACC:0]   sum_w;
`endif

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef NPU_CUBE_ACC_SAT_EN
    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    // Operand alignment: weighted bits above DW-1 are dropped.
    always_comb begin
        aux_ext = DW'(in_aux);
        op_a    = in_sum;
        op_b    = in_cay << CAY_SH;
        op_c    = aux_ext << AUX_SH;
        cpa     = s1_sum_q + (s1_cay_q << 1);
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_sum_d    = s1_sum_q;
        s1_cay_d    = s1_cay_q;
        s2_v_d      = s2_v_q;
        s2_val_d    = s2_val_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        len_eff     = len_q;
        cnt_inc     = {1'b0, cnt_q} + {{LENW{1'b0}}, 1'b1};
        acc_nxt     = acc_q;
`ifdef NPU_CUBE_ACC_SAT_EN
        ovf_d       = ovf_q;
        out_ovf_d   = out_ovf_q;
        ovf_nxt     = ovf_q;
        sum_w       = {1'b0, acc_q} + {1'b0, s2_val_q};
`endif

        if (!stall) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_sum_d = op_a ^ op_b ^ op_c;
                s1_cay_d = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
            end

            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_val_d = DWACC'(cpa);
            end

            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end

            if (s2_v_q) begin
                // The first beat of a run latches the length for the whole run.
                if (cnt_q == '0) begin
                    len_eff = (cfg_len == '0) ? LENW'(1) : cfg_len;
                    len_d   = len_eff;
                    acc_nxt = s2_val_q;
`ifdef NPU_CUBE_ACC_SAT_EN
                    ovf_nxt = 1'b0;
`endif
                end else begin
`ifdef NPU_CUBE_ACC_SAT_EN
                    acc_nxt = sum_w[DWACC] ? '1 : sum_w[DWACC-1:0];
                    ovf_nxt = ovf_q | sum_w[DWACC];
`else
                    acc_nxt = acc_q + s2_val_q;
`endif
                end

                if (cnt_inc == {1'b0, len_eff}) begin
                    out_data_d  = acc_nxt;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
`ifdef NPU_CUBE_ACC_SAT_EN
                    out_ovf_d   = ovf_nxt;
                    ovf_d       = 1'b0;
`endif
                end else begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_inc[LENW-1:0];
`ifdef NPU_CUBE_ACC_SAT_EN
                    ovf_d = ovf_nxt;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_sum_q    <= '0;
            s1_cay_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_val_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef NPU_CUBE_ACC_SAT_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            s1_v_q      <= s1_v_d;
            s1_sum_q    <= s1_sum_d;
            s1_cay_q    <= s1_cay_d;
            s2_v_q      <= s2_v_d;
            s2_val_q    <= s2_val_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef NPU_CUBE_ACC_SAT_EN
            ovf_q       <= ovf_d;
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_npu_cube_add_pipe_acc.sv
// Bench for npu_cube_add_pipe_acc: directed cases plus random traffic vs. a queue model.
// Runs a 32-bit and a 20-bit accumulator instance side by side.
module tb_npu_cube_add_pipe_acc;

    typedef struct {
        longint unsigned d32;
        longint unsigned d20;
        bit              o32;
        bit              o20;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [18:0] in_sum = '0;
    logic [18:0] in_cay = '0;
    logic [14:0] in_aux = '0;
    logic [7:0]  cfg_len = 8'd1;

    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_data;
    logic        in_ready20, out_valid20, out_ovf20;
    logic [19:0] out_data20;

    int total = 0;
    int bad = 0;
    int nout = 0;
    bit rnd_rdy = 0;

    longint unsigned last_d, last_d20;
    logic            last_o20;

    exp_t q[$];
    int unsigned mcnt = 0;
    int unsigned mlen = 1;
    longint unsigned a32 = 0, a20 = 0;
    bit o32 = 0, o20 = 0;

    npu_cube_add_pipe_acc u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cay(in_cay), .in_aux(in_aux),
        .cfg_len(cfg_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    npu_cube_add_pipe_acc #(.DWACC(20)) u_dut20 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready20),
        .in_sum(in_sum), .in_cay(in_cay), .in_aux(in_aux),
        .cfg_len(cfg_len),
        .out_valid(out_valid20), .out_ready(out_ready),
        .out_data(out_data20), .out_ovf(out_ovf20)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Arithmetic value of a beat: weighted sum of the three inputs mod 2^19.
    function automatic longint unsigned beat_val(input longint unsigned s,
                                                 input longint unsigned c,
                                                 input longint unsigned a);
        longint unsigned m = 64'd1 << 19;
        return (s + ((c * 2) % m) + ((a * 32) % m)) % m;
    endfunction

    function automatic void accum(input longint unsigned v, input int w, input bit first,
                                  inout longint unsigned acc, inout bit ovf);
        longint unsigned mx = (64'd1 << w) - 1;
        longint unsigned s;
        if (first) begin
            acc = v;
            ovf = 0;
        end else begin
            s = acc + v;
`ifdef NPU_CUBE_ACC_SAT_EN
            if (s > mx) begin
                s = mx;
                ovf = 1;
            end
`else
            s = s & mx;
`endif
            acc = s;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        longint unsigned v;
        if (rst) begin
            mcnt = 0;
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("data32", 64'(out_data), 64'(e.d32));
                    chk("data20", 64'(out_data20), 64'(e.d20));
                    chk("ovf32", 64'(out_ovf), 64'(e.o32));
                    chk("ovf20", 64'(out_ovf20), 64'(e.o20));
                    chk("valid20", 64'(out_valid20), 64'd1);
                    last_d   = out_data;
                    last_d20 = out_data20;
                    last_o20 = out_ovf20;
                    nout++;
                end
            end
            if (in_valid && in_ready) begin
                chk("ready20", 64'(in_ready20), 64'd1);
                v = beat_val(in_sum, in_cay, in_aux);
                if (mcnt == 0) mlen = (cfg_len == 0) ? 1 : cfg_len;
                accum(v, 32, mcnt == 0, a32, o32);
                accum(v, 20, mcnt == 0, a20, o20);
                mcnt++;
                if (mcnt == mlen) begin
                    e.d32 = a32;
                    e.d20 = a20;
                    e.o32 = o32;
                    e.o20 = o20;
                    q.push_back(e);
                    mcnt = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [18:0] s, input logic [18:0] c,
                        input logic [14:0] a, output int waits);
        in_valid = 1'b1;
        in_sum = s;
        in_cay = c;
        in_aux = a;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready || waits > 200) break;
            waits++;
            @(posedge clk);
            #1;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        idle(2);
    endtask

    initial begin
        int w;
        int base;
        int le;
        int n;

        idle(2);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // single beat, latency and one-cycle valid
        cfg_len = 8'd1;
        send(19'd3, 19'd2, 15'd1, w);
        chk("lat_t1", 64'(out_valid), 64'd0);
        idle(1);
        chk("lat_t2", 64'(out_valid), 64'd0);
        idle(1);
        chk("lat_t3", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'd39);
        idle(1);
        chk("lat_t4", 64'(out_valid), 64'd0);
        drain();

        // accumulate four beats of 39
        cfg_len = 8'd4;
        for (int i = 0; i < 4; i++) begin
            send(19'd3, 19'd2, 15'd1, w);
            chk("acc_ready", 64'(w), 64'd0);
        end
        drain();
        chk("acc_sum", 64'(last_d), 64'd156);

        // every weighted bit falls off the top
        cfg_len = 8'd1;
        send(19'd0, 19'h40000, 15'h4000, w);
        drain();
        chk("trunc", 64'(last_d), 64'd0);

        // backpressure
        base = nout;
        out_ready = 1'b0;
        send(19'd1, 19'd0, 15'd0, w);
        send(19'd2, 19'd0, 15'd0, w);
        send(19'd3, 19'd0, 15'd0, w);
        idle(1);
        @(negedge clk);
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", 64'(out_data), 64'd1);
        @(posedge clk);
        #1;
        idle(3);
        out_ready = 1'b1;
        drain();
        chk("bp_count", 64'(nout - base), 64'd3);
        chk("bp_last", 64'(last_d), 64'd3);

        // reset in the middle of an accumulation
        cfg_len = 8'd4;
        send(19'd3, 19'd2, 15'd1, w);
        send(19'd3, 19'd2, 15'd1, w);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        idle(1);
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) send(19'd1, 19'd0, 15'd0, w);
        drain();
        chk("rst_sum", 64'(last_d), 64'd4);

        // saturation / wrap on the 20-bit instance
        for (int i = 0; i < 4; i++) send(19'd524287, 19'd0, 15'd0, w);
        drain();
        chk("big32", 64'(last_d), 64'd2097148);
`ifdef NPU_CUBE_ACC_SAT_EN
        chk("sat20", 64'(last_d20), 64'd1048575);
        chk("satovf20", 64'(last_o20), 64'd1);
`else
        chk("wrap20", 64'(last_d20), 64'd1048572);
        chk("wrapovf20", 64'(last_o20), 64'd0);
`endif

        // random traffic with random downstream stalls
        for (int ph = 0; ph < 8; ph++) begin
            cfg_len = 8'($urandom_range(0, 5));
            le = (cfg_len == 0) ? 1 : int'(cfg_len);
            n = le * int'($urandom_range(1, 4));
            rnd_rdy = 1'b1;
            for (int i = 0; i < n; i++) begin
                send(19'($urandom), 19'($urandom), 15'($urandom), w);
                idle(int'($urandom_range(0, 2)));
            end
            rnd_rdy = 1'b0;
            @(posedge clk);
            #2;
            out_ready = 1'b1;
            drain();
        end

        chk("final_queue", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
